// File: rtl/commit_tracker.sv
// commit_tracker: in-order commit aggregator between the MPU and the TPU array.
// Holds up to DEPTH outstanding issues, each with a per-TPU pending mask.
// Terminations clear pending bits. The head entry is offered for commit once
// its mask is empty. Commits leave strictly in issue order.
module commit_tracker #(
  parameter int NUM_ROWS = 2,
  parameter int NUM_CLMS = 2,
  parameter int ISSUE_W  = 8,
  parameter int DEPTH    = 4,
  localparam int NUM_TPU = NUM_ROWS * NUM_CLMS,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       I_Req,
  input  logic [ISSUE_W-1:0]         I_Issue_No,
  input  logic [NUM_TPU-1:0]         I_En_TPU,
  input  logic [NUM_TPU-1:0]         I_Term,
  input  logic [NUM_TPU*ISSUE_W-1:0] I_Term_No,
  output logic                       O_Commit_Req,
  output logic [ISSUE_W-1:0]         O_Commit_No,
  input  logic                       I_Commit_Rdy,
  output logic                       O_Full,
  output logic                       O_Empty,
  output logic [CNT_W-1:0]           O_Count,
  output logic                       O_Overflow,
  output logic                       O_Orphan
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Table storage: one valid bit, issue number and pending mask per slot.
  logic [DEPTH-1:0]   entry_valid;
  logic [ISSUE_W-1:0] entry_no   [DEPTH];
  logic [NUM_TPU-1:0] entry_pend [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             orphan;

  logic [NUM_TPU-1:0] clr_mask [DEPTH];
  logic               orphan_set;
  logic               found;
  logic [PTR_W-1:0]   idx;

  logic full;
  logic empty;
  logic commit_req;
  logic push;
  logic pop;

  // Pointer advance with wrap at DEPTH. DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr, input int step);
    int sum;
    sum = int'(ptr) + step;
    if (sum >= DEPTH) sum = sum - DEPTH;
    return PTR_W'(sum);
  endfunction

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign commit_req = entry_valid[head] && (entry_pend[head] == '0);
  assign push       = I_Req && !full;
  assign pop        = commit_req && I_Commit_Rdy;

  // Per-TPU search from head for the oldest valid entry still waiting on that TPU's issue.
  always_comb begin
    orphan_set = 1'b0;
    found      = 1'b0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      clr_mask[i] = '0;
    end
    for (int t = 0; t < NUM_TPU; t++) begin
      found = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        idx = wrap_add(head, k);
        if (I_Term[t] && !found && entry_valid[idx] && entry_pend[idx][t] &&
            (entry_no[idx] == I_Term_No[t*ISSUE_W +: ISSUE_W])) begin
          clr_mask[idx][t] = 1'b1;
          found            = 1'b1;
        end
      end
      if (I_Term[t] && !found) begin
        orphan_set = 1'b1;
      end
    end
  end

  // Table, pointers, count and sticky flags. A push writes a slot that is
  // invalid at the start of the cycle, so it never collides with a clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      entry_valid <= '0;
      overflow    <= 1'b0;
      orphan      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_no[i]   <= '0;
        entry_pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_pend[i] <= entry_pend[i] & ~clr_mask[i];
      end
      if (pop) begin
        entry_valid[head] <= 1'b0;
        head              <= wrap_add(head, 1);
      end
      if (push) begin
        entry_valid[tail] <= 1'b1;
        entry_no[tail]    <= I_Issue_No;
        entry_pend[tail]  <= I_En_TPU;
        tail              <= wrap_add(tail, 1);
      end
      if (I_Req && full) begin
        overflow <= 1'b1;
      end
      if (orphan_set) begin
        orphan <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign O_Commit_Req = commit_req;
  assign O_Commit_No  = entry_no[head];
  assign O_Full       = full;
  assign O_Empty      = empty;
  assign O_Count      = count;
  assign O_Overflow   = overflow;
  assign O_Orphan     = orphan;

endmodule

// File: tb/tb_commit_tracker.sv
// tb_commit_tracker: directed test of commit_tracker with a 2x2 array, 8-bit issue numbers and 4 table entries.
module tb_commit_tracker;

  logic        clock;
  logic        reset;
  logic        I_Req;
  logic [7:0]  I_Issue_No;
  logic [3:0]  I_En_TPU;
  logic [3:0]  I_Term;
  logic [31:0] I_Term_No;
  logic        O_Commit_Req;
  logic [7:0]  O_Commit_No;
  logic        I_Commit_Rdy;
  logic        O_Full;
  logic        O_Empty;
  logic [2:0]  O_Count;
  logic        O_Overflow;
  logic        O_Orphan;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  commit_tracker #(
    .NUM_ROWS(2),
    .NUM_CLMS(2),
    .ISSUE_W (8),
    .DEPTH   (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .I_Req       (I_Req),
    .I_Issue_No  (I_Issue_No),
    .I_En_TPU    (I_En_TPU),
    .I_Term      (I_Term),
    .I_Term_No   (I_Term_No),
    .O_Commit_Req(O_Commit_Req),
    .O_Commit_No (O_Commit_No),
    .I_Commit_Rdy(I_Commit_Rdy),
    .O_Full      (O_Full),
    .O_Empty     (O_Empty),
    .O_Count     (O_Count),
    .O_Overflow  (O_Overflow),
    .O_Orphan    (O_Orphan)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive one cycle of inputs, then advance past the rising edge so the
  // registered outputs of that edge can be sampled.
  task automatic applyStimulus(input logic req, input logic [7:0] no, input logic [3:0] en,
                               input logic [3:0] term, input logic [31:0] term_no,
                               input logic rdy);
    I_Req        = req;
    I_Issue_No   = no;
    I_En_TPU     = en;
    I_Term       = term;
    I_Term_No    = term_no;
    I_Commit_Rdy = rdy;
    @(posedge clock);
    #1;
  endtask

  // One comparison of an observed output against its hand-computed value.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Directed sequence covering reset, in-order commit, overflow, orphan, backpressure and mid-run reset.
  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 8'd0, 4'h0, 4'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 8'd0, 4'h0, 4'h0, 32'h0, 1'b0);
    reset = 1'b0;
    checkOutput("rst_count", O_Count, 0);
    checkOutput("rst_empty", O_Empty, 1);
    checkOutput("rst_full", O_Full, 0);
    checkOutput("rst_req", O_Commit_Req, 0);
    checkOutput("rst_no", O_Commit_No, 0);
    checkOutput("rst_ovf", O_Overflow, 0);
    checkOutput("rst_orph", O_Orphan, 0);

    // Issue 5 on all TPUs and terminate them one per cycle.
    applyStimulus(1'b1, 8'd5, 4'hF, 4'h0, 32'h0, 1'b1);
    checkOutput("t1_count_push", O_Count, 1);
    checkOutput("t1_req_push", O_Commit_Req, 0);
    applyStimulus(1'b0, 8'd0, 4'h0, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd5}, 1'b1);
    applyStimulus(1'b0, 8'd0, 4'h0, 4'b0010, {8'd0, 8'd0, 8'd5, 8'd0}, 1'b1);
    applyStimulus(1'b0, 8'd0, 4'h0, 4'b0100, {8'd0, 8'd5, 8'd0, 8'd0}, 1'b1);
    checkOutput("t1_req_3terms", O_Commit_Req, 0);
    applyStimulus(1'b0, 8'd0, 4'h0, 4'b1000, {8'd5, 8'd0, 8'd0, 8'd0}, 1'b1);
    checkOutput("t1_req", O_Commit_Req, 1);
    checkOutput("t1_no", O_Commit_No, 5);
    checkOutput("t1_count_pre", O_Count, 1);
    applyStimulus(1'b0, 8'd0, 4'h0, 4'h0, 32'h0, 1'b1);
    checkOutput("t1_count_post", O_Count, 0);
    checkOutput("t1_req_post", O_Commit_Req, 0);
    checkOutput("t1_empty_post", O_Empty, 1);

    // Younger issue 8 completes first but must wait behind 7.
    applyStimulus(1'b1, 8'd7, 4'b0011, 4'h0, 32'h0, 1'b1);
    applyStimulus(1'b1, 8'd8, 4'b0001, 4'h0, 32'h0, 1'b1);
    checkOutput("t2_count", O_Count, 2);
    applyStimulus(1'b0, 8'd0, 4'h0, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd8}, 1'b1);
    checkOutput("t2_req_blocked", O_Commit_Req, 0);
    checkOutput("t2_head_no", O_Commit_No, 7);
    checkOutput("t2_orph_none", O_Orphan, 0);
    applyStimulus(1'b0, 8'd0, 4'h0, 4'b0011, {8'd0, 8'd0, 8'd7, 8'd7}, 1'b1);
    checkOutput("t2_req7", O_Commit_Req, 1);
    checkOutput("t2_no7", O_Commit_No, 7);
    applyStimulus(1'b0, 8'd0, 4'h0, 4'h0, 32'h0, 1'b1);
    checkOutput("t2_req8", O_Commit_Req, 1);
    checkOutput("t2_no8", O_Commit_No, 8);
    checkOutput("t2_count8", O_Count, 1);
    applyStimulus(1'b0, 8'd0, 4'h0, 4'h0, 32'h0, 1'b1);
    checkOutput("t2_count_end", O_Count, 0);
    checkOutput("t2_req_end", O_Commit_Req, 0);

    // Fill the table and overflow it.
    applyStimulus(1'b1, 8'd10, 4'b0001, 4'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 8'd11, 4'b0001, 4'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 8'd12, 4'b0001, 4'h0, 32'h0, 1'b0);
    checkOutput("t3_full_3", O_Full, 0);
    applyStimulus(1'b1, 8'd13, 4'b0001, 4'h0, 32'h0, 1'b0);
    checkOutput("t3_full", O_Full, 1);
    checkOutput("t3_count4", O_Count, 4);
    checkOutput("t3_ovf_pre", O_Overflow, 0);
    applyStimulus(1'b1, 8'd14, 4'b0001, 4'h0, 32'h0, 1'b0);
    checkOutput("t3_ovf", O_Overflow, 1);
    checkOutput("t3_count_hold", O_Count, 4);
    checkOutput("t3_head_no", O_Commit_No, 10);

    // Termination for an issue nobody is waiting on.
    applyStimulus(1'b0, 8'd0, 4'h0, 4'b0100, {8'd0, 8'd9, 8'd0, 8'd0}, 1'b0);
    checkOutput("t4_orph", O_Orphan, 1);
    checkOutput("t4_count", O_Count, 4);
    checkOutput("t4_req", O_Commit_Req, 0);

    // Complete head 10 and hold it under backpressure.
    applyStimulus(1'b0, 8'd0, 4'h0, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd10}, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checkOutput("t5_req_hold", O_Commit_Req, 1);
      checkOutput("t5_no_hold", O_Commit_No, 10);
      checkOutput("t5_count_hold", O_Count, 4);
      applyStimulus(1'b0, 8'd0, 4'h0, 4'h0, 32'h0, 1'b0);
    end
    checkOutput("t5_req_hold3", O_Commit_Req, 1);
    applyStimulus(1'b0, 8'd0, 4'h0, 4'h0, 32'h0, 1'b1);
    checkOutput("t5_count_pop", O_Count, 3);
    checkOutput("t5_no_next", O_Commit_No, 11);
    checkOutput("t5_req_next", O_Commit_Req, 0);

    // Push and pop in the same cycle leave the count alone.
    applyStimulus(1'b0, 8'd0, 4'h0, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd11}, 1'b0);
    checkOutput("pp_req11", O_Commit_Req, 1);
    applyStimulus(1'b1, 8'd20, 4'h0, 4'h0, 32'h0, 1'b1);
    checkOutput("pp_count", O_Count, 3);
    checkOutput("pp_no12", O_Commit_No, 12);
    checkOutput("pp_req12", O_Commit_Req, 0);

    // Reset with three entries outstanding and both sticky flags set.
    reset = 1'b1;
    applyStimulus(1'b1, 8'd30, 4'h0, 4'h0, 32'h0, 1'b1);
    reset = 1'b0;
    checkOutput("t6_count", O_Count, 0);
    checkOutput("t6_empty", O_Empty, 1);
    checkOutput("t6_req", O_Commit_Req, 0);
    checkOutput("t6_ovf", O_Overflow, 0);
    checkOutput("t6_orph", O_Orphan, 0);

    // A zero enable mask commits in the cycle after its push.
    applyStimulus(1'b1, 8'd33, 4'h0, 4'h0, 32'h0, 1'b0);
    checkOutput("zm_req", O_Commit_Req, 1);
    checkOutput("zm_no", O_Commit_No, 33);
    applyStimulus(1'b0, 8'd0, 4'h0, 4'h0, 32'h0, 1'b1);
    checkOutput("zm_empty", O_Empty, 1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
